// File: rtl/p_uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding,
// default packet width and an ID-width helper.
package p_uart_pkg;

  // 2-bit state encodings for the launch sequencer
  localparam logic [1:0] IDLE_ENC      = 2'd0;
  localparam logic [1:0] WAIT_RISE_ENC = 2'd1;
  localparam logic [1:0] WAIT_FALL_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = IDLE_ENC,
    WAIT_RISE = WAIT_RISE_ENC,
    WAIT_FALL = WAIT_FALL_ENC
  } arb_state_t;

  // Packet width of p_uart_send's uart_din
  localparam int P_DATA_W = 128;

  // Ceiling log2 with a floor of 1 so single-entry cases still get a 1-bit field
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/p_uart_tx_arb_if.sv
// Requester/launch bundle between the packet sources, the arbiter and
// p_uart_send.
//
// Handshake: a requester raises req_valid[i] with req_data[i] stable and
// holds both until req_ack[i] pulses (or it withdraws valid); the packet is
// captured on the ack cycle. req_done[i] or req_err[i] later closes the
// transfer with a single-cycle pulse. uart_en is a one-cycle launch strobe
// with uart_din held from launch until done/err; uart_tx_busy is the
// transmitter's level busy flag.
interface p_uart_tx_arb_if
  import p_uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = P_DATA_W
);
  localparam int ID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic                      uart_en;
  logic [DATA_W-1:0]         uart_din;
  logic                      uart_tx_busy;
  logic [ID_W-1:0]           grant_id;
  logic                      arb_busy;
  // Debug visibility of the sequencer state and round-robin pointer
  logic [1:0]                dbg_state;
  logic [ID_W-1:0]           dbg_ptr;

  modport slave (
    input  req_valid, req_data, uart_tx_busy,
    output req_ack, req_done, req_err, uart_en, uart_din,
           grant_id, arb_busy, dbg_state, dbg_ptr
  );

  modport master (
    output req_valid, req_data, uart_tx_busy,
    input  req_ack, req_done, req_err, uart_en, uart_din,
           grant_id, arb_busy, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/p_rr_arb.sv
// Combinational round-robin pick: first set request at or above the
// pointer, wrapping at NUM_REQ.
module p_rr_arb
  import p_uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_any
);

  localparam logic [ID_W:0] NR_L = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Scan upward from the pointer; the pointer is always < NUM_REQ so one
  // subtraction is enough to wrap.
  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= NR_L) w_sum = w_sum - NR_L;
      w_idx = w_sum[ID_W-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/p_uart_tx_arb.sv
// Shares one p_uart_send between NUM_REQ packet sources. Grants one packet
// at a time round-robin, launches it with a single uart_en pulse, then
// follows uart_tx_busy through its rise and fall to report done, or reports
// an error if busy never rises within BUSY_TO cycles.
module p_uart_tx_arb
  import p_uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = P_DATA_W,
  parameter int BUSY_TO = 16
) (
  input logic             sys_clk,
  input logic             sys_rst,
  p_uart_tx_arb_if.slave  bus
);

  localparam int              ID_W     = clog2(NUM_REQ);
  localparam int              CNT_W    = clog2(BUSY_TO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  arb_state_t          r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  r_err;
  logic                r_en;
  logic [DATA_W-1:0]   r_din;
  logic                r_arb_busy;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_id;
  logic                w_any;
  logic [DATA_W-1:0]   w_win_data;
  logic [ID_W-1:0]     w_ptr_next;
  logic [NUM_REQ-1:0]  w_own_oh;

  p_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_req    (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id),
    .o_any    (w_any)
  );

  // AND-OR select of the winning requester's packet using the one-hot grant
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_win_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next pointer favours the requester after the winner
  always_comb begin
    w_ptr_next = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
  end

  // One-hot of the current owner, used for the done/err pulses
  always_comb begin
    w_own_oh             = '0;
    w_own_oh[r_grant_id] = 1'b1;
  end

  // Launch sequencer: IDLE -> WAIT_RISE -> WAIT_FALL -> IDLE, all outputs registered
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_en       <= 1'b0;
      r_din      <= '0;
      r_arb_busy <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      r_err  <= '0;
      r_en   <= 1'b0;
      case (r_state)
        IDLE: begin
          // A leftover frame in the transmitter holds off arbitration
          if (!bus.uart_tx_busy && w_any) begin
            r_ack      <= w_gnt;
            r_en       <= 1'b1;
            r_din      <= w_win_data;
            r_grant_id <= w_gnt_id;
            r_ptr      <= w_ptr_next;
            r_cnt      <= '0;
            r_state    <= WAIT_RISE;
            r_arb_busy <= 1'b1;
          end
        end
        WAIT_RISE: begin
          if (bus.uart_tx_busy) begin
            r_state <= WAIT_FALL;
          end else if (r_cnt == CNT_LAST) begin
            r_err      <= w_own_oh;
            r_state    <= IDLE;
            r_arb_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_FALL: begin
          // Frame length belongs to p_uart_send, so no timeout here
          if (!bus.uart_tx_busy) begin
            r_done     <= w_own_oh;
            r_state    <= IDLE;
            r_arb_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_arb_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ack   = r_ack;
  assign bus.req_done  = r_done;
  assign bus.req_err   = r_err;
  assign bus.uart_en   = r_en;
  assign bus.uart_din  = r_din;
  assign bus.grant_id  = r_grant_id;
  assign bus.arb_busy  = r_arb_busy;
  assign bus.dbg_state = r_state;
  assign bus.dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_p_uart_tx_arb.sv
// Bench for p_uart_tx_arb with NUM_REQ=4, DATA_W=128, BUSY_TO=16.
module tb_p_uart_tx_arb;
  import p_uart_pkg::*;

  localparam int NR   = 4;
  localparam int DW   = 128;
  localparam int BT   = 16;
  localparam int ID_W = 2;

  localparam int MODE_MANUAL = 0;
  localparam int MODE_AUTO   = 1;
  localparam int MODE_NEVER  = 2;

  logic sys_clk;
  logic sys_rst;

  p_uart_tx_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  p_uart_tx_arb #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TO(BT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]   data_mem [NR];
  logic [ID_W-1:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- busy model (stands in for p_uart_send) ----------------
  int   busy_mode = MODE_MANUAL;
  logic busy_man  = 1'b0;
  int   hold_len  = 5;
  logic en_d1;
  logic model_busy;
  int   hold_cnt;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      en_d1      <= 1'b0;
      model_busy <= 1'b0;
      hold_cnt   <= 0;
    end else begin
      en_d1 <= bus.uart_en;
      if (en_d1 && busy_mode == MODE_AUTO) begin
        model_busy <= 1'b1;
        hold_cnt   <= hold_len;
      end else if (model_busy) begin
        if (hold_cnt <= 1) model_busy <= 1'b0;
        else hold_cnt <= hold_cnt - 1;
      end
    end
  end

  assign bus.uart_tx_busy = (busy_mode == MODE_MANUAL) ? busy_man : model_busy;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // which: 0 = wait for an ack, 1 = wait for done or err
  task automatic wait_ev(input string name, input int which, input int max_cyc, output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_cyc) begin
      tick();
      n++;
      if (which == 0) seen = |bus.req_ack;
      else            seen = (|bus.req_done) || (|bus.req_err);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  logic [ID_W-1:0] out_id;
  bit              have_out = 1'b0;

  always @(negedge sys_clk) begin : mon
    logic [ID_W-1:0] e;
    logic            ok;
    if (sys_rst) begin
      have_out = 1'b0;
    end else begin
      ok = $onehot0(bus.req_ack) && $onehot0(bus.req_done) && $onehot0(bus.req_err) &&
           $onehot0({|bus.req_ack, |bus.req_done, |bus.req_err}) &&
           (bus.uart_en == (|bus.req_ack));
      chk("pulse_rules", DW'(ok), DW'(1'b1));
      if (|bus.req_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_ack: unexpected grant ack=%b, required none", bus.req_ack);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ack_id", DW'(bus.req_ack), DW'(oh(int'(e))));
          chk("sb_din", bus.uart_din, data_mem[e]);
          out_id   = e;
          have_out = 1'b1;
        end
      end
      if ((|bus.req_done) || (|bus.req_err)) begin
        if (!have_out) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_end: done=%b err=%b with no transfer outstanding", bus.req_done, bus.req_err);
        end else begin
          chk("sb_end_owner", DW'(bus.req_done | bus.req_err), DW'(oh(int'(out_id))));
        end
        have_out = 1'b0;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [NR-1:0] valid;
    int            win;
    int            ptr_after;
  } vec_t;

  vec_t tbl [10];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int early;

    tbl[0] = '{4'b1111, 3, 0};
    tbl[1] = '{4'b1111, 0, 1};
    tbl[2] = '{4'b1111, 1, 2};
    tbl[3] = '{4'b1111, 2, 3};
    tbl[4] = '{4'b1111, 3, 0};
    tbl[5] = '{4'b1111, 0, 1};
    tbl[6] = '{4'b1010, 1, 2};
    tbl[7] = '{4'b0011, 0, 1};
    tbl[8] = '{4'b1001, 3, 0};
    tbl[9] = '{4'b0110, 1, 2};

    for (int i = 0; i < NR; i++) data_mem[i] = {4{32'hA5C3_0000 | 32'(i)}};
    data_mem[2] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = data_mem[i];
    bus.req_valid = '0;

    // Reset with busy already high (leftover frame)
    sys_rst   = 1'b1;
    busy_mode = MODE_MANUAL;
    busy_man  = 1'b1;
    repeat (3) tick();
    chk("rst_ack",      DW'(bus.req_ack),   '0);
    chk("rst_done",     DW'(bus.req_done),  '0);
    chk("rst_err",      DW'(bus.req_err),   '0);
    chk("rst_en",       DW'(bus.uart_en),   '0);
    chk("rst_din",      bus.uart_din,       '0);
    chk("rst_grant_id", DW'(bus.grant_id),  '0);
    chk("rst_arb_busy", DW'(bus.arb_busy),  '0);
    chk("rst_state",    DW'(bus.dbg_state), DW'(IDLE_ENC));
    chk("rst_ptr",      DW'(bus.dbg_ptr),   '0);

    // Busy held 50 cycles after release with requester 0 pending
    sys_rst       = 1'b0;
    bus.req_valid = 4'b0001;
    early = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if ((|bus.req_ack) || bus.uart_en) early++;
    end
    chk("t4_no_early_grant", DW'(early), '0);
    exp_q.push_back(2'd0);
    busy_man = 1'b0;
    wait_ev("t4_ack", 0, 10, n);
    chk("t4_ack_latency", DW'(n), DW'(1));
    chk("t4_grant_id",    DW'(bus.grant_id), DW'(0));
    bus.req_valid = '0;
    tick();
    tick();
    busy_man = 1'b1;
    repeat (5) tick();
    busy_man = 1'b0;
    wait_ev("t4_done", 1, 10, n);
    chk("t4_done_latency", DW'(n), DW'(1));
    chk("t4_done_vec",     DW'(bus.req_done), DW'(4'b0001));

    // Single request to requester 2, 100-cycle frame, with a withdrawn pulse on 3
    busy_mode = MODE_AUTO;
    hold_len  = 100;
    exp_q.push_back(2'd2);
    bus.req_valid = 4'b0100;
    wait_ev("t1_ack", 0, 10, n);
    chk("t1_ack_latency", DW'(n), DW'(1));
    chk("t1_ack_vec",     DW'(bus.req_ack), DW'(4'b0100));
    chk("t1_uart_en",     DW'(bus.uart_en), DW'(1));
    chk("t1_din",         bus.uart_din, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_grant_id",    DW'(bus.grant_id), DW'(2));
    chk("t1_arb_busy",    DW'(bus.arb_busy), DW'(1));
    bus.req_valid = '0;
    repeat (10) tick();
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    wait_ev("t1_done", 1, 300, n);
    chk("t1_done_time",   DW'(11 + n), DW'(103));
    chk("t1_done_vec",    DW'(bus.req_done), DW'(4'b0100));
    chk("t1_din_stable",  bus.uart_din, data_mem[2]);
    chk("t6_ptr_kept",    DW'(bus.dbg_ptr), DW'(3));

    // Table: round-robin under load and assorted request patterns
    hold_len = 5;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(ID_W'(tbl[i].win));
      bus.req_valid = tbl[i].valid;
      wait_ev($sformatf("tbl%0d_ack", i), 0, 10, n);
      chk($sformatf("tbl%0d_gap", i),      DW'(n), DW'(1));
      chk($sformatf("tbl%0d_ack_vec", i),  DW'(bus.req_ack), DW'(oh(tbl[i].win)));
      chk($sformatf("tbl%0d_grant_id", i), DW'(bus.grant_id), DW'(tbl[i].win));
      chk($sformatf("tbl%0d_ptr", i),      DW'(bus.dbg_ptr), DW'(tbl[i].ptr_after));
      wait_ev($sformatf("tbl%0d_done", i), 1, 40, n);
      chk($sformatf("tbl%0d_done_time", i), DW'(n), DW'(8));
      chk($sformatf("tbl%0d_done_vec", i),  DW'(bus.req_done), DW'(oh(tbl[i].win)));
      if (i == 9) bus.req_valid = '0;
    end

    // Busy never rises: error after BUSY_TO cycles, then a fresh grant
    busy_mode = MODE_NEVER;
    exp_q.push_back(2'd0);
    bus.req_valid = 4'b0001;
    wait_ev("t3_ack", 0, 10, n);
    chk("t3_ack_latency", DW'(n), DW'(1));
    bus.req_valid = '0;
    wait_ev("t3_err", 1, 40, n);
    chk("t3_err_time", DW'(n), DW'(16));
    chk("t3_err_vec",  DW'(bus.req_err),  DW'(4'b0001));
    chk("t3_no_done",  DW'(bus.req_done), '0);
    busy_mode = MODE_AUTO;
    exp_q.push_back(2'd2);
    bus.req_valid = 4'b0100;
    wait_ev("t3_next_ack", 0, 10, n);
    chk("t3_next_latency",  DW'(n), DW'(1));
    chk("t3_next_grant_id", DW'(bus.grant_id), DW'(2));
    bus.req_valid = '0;
    wait_ev("t3_next_done", 1, 40, n);
    chk("t3_next_done_time", DW'(n), DW'(8));

    // Reset during WAIT_FALL
    hold_len = 100;
    exp_q.push_back(2'd0);
    bus.req_valid = 4'b0001;
    wait_ev("t5_ack", 0, 10, n);
    chk("t5_grant_id", DW'(bus.grant_id), DW'(0));
    bus.req_valid = '0;
    repeat (10) tick();
    chk("t5_in_wait_fall", DW'(bus.dbg_state), DW'(WAIT_FALL_ENC));
    #2;
    sys_rst = 1'b1;
    #1;
    chk("t5_async_din",      bus.uart_din,       '0);
    chk("t5_async_arb_busy", DW'(bus.arb_busy),  '0);
    chk("t5_async_state",    DW'(bus.dbg_state), DW'(IDLE_ENC));
    chk("t5_async_en",       DW'(bus.uart_en),   '0);
    chk("t5_async_pulses",   DW'({bus.req_ack, bus.req_done, bus.req_err}), '0);
    tick();
    tick();
    sys_rst  = 1'b0;
    hold_len = 5;
    chk("t5_grant_id_after", DW'(bus.grant_id), '0);
    chk("t5_ptr_after",      DW'(bus.dbg_ptr),  '0);
    exp_q.push_back(2'd1);
    bus.req_valid = 4'b1010;
    wait_ev("t5_first_ack", 0, 10, n);
    chk("t5_first_latency",  DW'(n), DW'(1));
    chk("t5_first_grant_id", DW'(bus.grant_id), DW'(1));
    bus.req_valid = '0;
    wait_ev("t5_done", 1, 40, n);
    chk("t5_done_time", DW'(n), DW'(8));
    repeat (3) tick();

    chk("sb_queue_empty", DW'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
